// File: rtl/ov7670_frame_writer.sv
// rtl/ov7670_frame_writer.sv - double-buffered frame-buffer write controller for the OV7670 receiver
// Linearises (h, v) into a BRAM word address through a 2-stage pipeline and swaps banks with the VGA side.
module ov7670_frame_writer #(
    parameter int H_WIDTH    = 320,
    parameter int V_WIDTH    = 240,
    parameter int PXL_WIDTH  = 16,
    parameter int ADDR_WIDTH = $clog2(H_WIDTH * V_WIDTH)
) (
    input  logic                       i_clk,
    input  logic                       i_n_reset,
    input  logic                       i_enable,
    input  logic [PXL_WIDTH-1:0]       i_pixel_data,
    input  logic [$clog2(H_WIDTH)-1:0] i_h_addr,
    input  logic [$clog2(V_WIDTH)-1:0] i_v_addr,
    input  logic                       i_valid,
    output logic                       o_next_frame,
    output logic                       o_wr_en,
    output logic                       o_wr_bank,
    output logic [ADDR_WIDTH-1:0]      o_wr_addr,
    output logic [PXL_WIDTH-1:0]       o_wr_data,
    input  logic                       i_rd_frame_req,
    output logic                       o_rd_bank,
    output logic                       o_frame_done,
    output logic                       o_range_err,
    output logic [2:0]                 o_state
);
    localparam int H_BITS = $clog2(H_WIDTH);
    localparam int V_BITS = $clog2(V_WIDTH);
    localparam logic [H_BITS-1:0]     H_MAX   = H_BITS'(H_WIDTH - 1);
    localparam logic [V_BITS-1:0]     V_MAX   = V_BITS'(V_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] H_CONST = ADDR_WIDTH'(H_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FIRST = 3'd1,
        S_WRITE      = 3'd2,
        S_DRAIN      = 3'd3,
        S_READY      = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_in_range;
    logic w_origin;
    logic w_last;
    logic w_accept;
    logic w_swap;
    logic w_next_frame;
    logic w_range_hit;
    logic w_s1_fire;

    logic                  r_s1_valid;
    logic [PXL_WIDTH-1:0]  r_s1_data;
    logic [H_BITS-1:0]     r_s1_h;
    logic [ADDR_WIDTH-1:0] r_s1_row;
    logic                  r_s1_last;

    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [PXL_WIDTH-1:0]  r_wr_data;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic                  r_next_frame;
    logic                  r_frame_done;
    logic                  r_range_err;

    always_comb begin
        w_in_range = (i_h_addr <= H_MAX) && (i_v_addr <= V_MAX);
        w_origin   = (i_h_addr == '0) && (i_v_addr == '0);
        w_last     = (i_h_addr == H_MAX) && (i_v_addr == V_MAX);
        // Dropping i_enable squashes stage 1 so in-flight pixels never reach the BRAM
        w_s1_fire  = i_enable && r_s1_valid;
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_swap       = 1'b0;
        w_next_frame = 1'b0;
        w_range_hit  = 1'b0;
        if (!i_enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_WAIT_FIRST;
                    w_next_frame = 1'b1;
                end
                S_WAIT_FIRST: begin
                    w_range_hit = i_valid && !w_in_range;
                    if (i_valid && w_in_range && w_origin) begin
                        w_accept     = 1'b1;
                        w_next_state = S_WRITE;
                    end
                end
                S_WRITE: begin
                    w_range_hit = i_valid && !w_in_range;
                    if (i_valid && w_in_range) begin
                        w_accept = 1'b1;
                        if (w_last) begin
                            w_next_state = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Stage 1 empty means the final write is on the bus this cycle
                    if (!r_s1_valid) begin
                        w_next_state = S_READY;
                    end
                end
                S_READY: begin
                    if (i_rd_frame_req) begin
                        w_swap       = 1'b1;
                        w_next_frame = 1'b1;
                        w_next_state = S_WAIT_FIRST;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_h       <= '0;
            r_s1_row     <= '0;
            r_s1_last    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b1;
            r_next_frame <= 1'b0;
            r_frame_done <= 1'b0;
            r_range_err  <= 1'b0;
        end else begin
            r_next_frame <= w_next_frame;
            r_range_err  <= r_range_err | w_range_hit;
            if (w_swap) begin
                r_wr_bank <= ~r_wr_bank;
                r_rd_bank <= r_wr_bank;
            end
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= i_pixel_data;
                r_s1_h    <= i_h_addr;
                r_s1_row  <= ADDR_WIDTH'(i_v_addr) * H_CONST;
                r_s1_last <= w_last;
            end
            r_wr_en      <= w_s1_fire;
            r_frame_done <= w_s1_fire && r_s1_last;
            if (w_s1_fire) begin
                r_wr_addr <= r_s1_row + ADDR_WIDTH'(r_s1_h);
                r_wr_data <= r_s1_data;
            end
        end
    end

    assign o_next_frame = r_next_frame;
    assign o_wr_en      = r_wr_en;
    assign o_wr_bank    = r_wr_bank;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_rd_bank    = r_rd_bank;
    assign o_frame_done = r_frame_done;
    assign o_range_err  = r_range_err;
    assign o_state      = r_state;
endmodule
